// File: rtl/key_sr_pkg.sv
// Shared types and constants for the key-driven SR latch driver.
package key_sr_pkg;

  // Width of the pulse-length counter; pulses are 1..15 cycles long.
  localparam int PCNT_W = 4;

  // Driver FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE_S  = 2'd1,
    PULSE_R  = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stability-counter debouncer for one raw key.
// The level follows the synchronized key only after DB_LIMIT consecutive
// disagreeing samples; rise pulses for one cycle when the level goes 0->1.
module key_debounce #(
  parameter int DB_LIMIT = 50000,
  parameter int DB_W     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic level,
  output logic rise
);

  localparam logic [DB_W-1:0] LAST = DB_W'(DB_LIMIT - 1);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;

  // Bring the asynchronous key into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_sr_driver.sv
// Turns debounced set/clear buttons into fixed-width active-low pulses for a
// downstream NAND SR latch, tracking the latch state those pulses imply.
// Optional feature macro KEY_SR_LATCH_CHECK_EN adds a latch readback input
// (latch_q) and a sticky mismatch flag (err).
module key_sr_driver
  import key_sr_pkg::*;
#(
  parameter int DB_LIMIT     = 50000,
  parameter int DB_W         = 16,
  parameter int PULSE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_set,
  input  logic key_clr,
  output logic notS,
  output logic notR,
  output logic q_expect,
  output logic busy
`ifdef KEY_SR_LATCH_CHECK_EN
  ,
  input  logic latch_q,
  output logic err
`endif
);

  localparam logic [PCNT_W-1:0] PLAST = PCNT_W'(PULSE_CYCLES - 1);

  logic              set_level;
  logic              set_rise;
  logic              clr_level;
  logic              clr_rise;
  state_t            state;
  state_t            state_n;
  logic [PCNT_W-1:0] pcnt;
  logic [PCNT_W-1:0] pcnt_n;
  logic              nots_n;
  logic              notr_n;
  logic              q_n;

  key_debounce #(.DB_LIMIT(DB_LIMIT), .DB_W(DB_W)) u_db_set (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key_set),
    .level (set_level),
    .rise  (set_rise)
  );

  key_debounce #(.DB_LIMIT(DB_LIMIT), .DB_W(DB_W)) u_db_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key_clr),
    .level (clr_level),
    .rise  (clr_rise)
  );

  // Next-state logic; pulse outputs are computed here and registered below.
  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    nots_n  = 1'b1;
    notr_n  = 1'b1;
    q_n     = q_expect;
    case (state)
      IDLE: begin
        if (clr_rise) begin
          state_n = PULSE_R;
          pcnt_n  = '0;
          notr_n  = 1'b0;
        end else if (set_rise) begin
          state_n = PULSE_S;
          pcnt_n  = '0;
          nots_n  = 1'b0;
        end
      end
      PULSE_S: begin
        if (pcnt == PLAST) begin
          state_n = WAIT_REL;
          q_n     = 1'b1;
        end else begin
          pcnt_n = pcnt + 1'b1;
          nots_n = 1'b0;
        end
      end
      PULSE_R: begin
        if (pcnt == PLAST) begin
          state_n = WAIT_REL;
          q_n     = 1'b0;
        end else begin
          pcnt_n = pcnt + 1'b1;
          notr_n = 1'b0;
        end
      end
      WAIT_REL: begin
        if (!set_level && !clr_level) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counter and glitch-free pulse outputs straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pcnt     <= '0;
      notS     <= 1'b1;
      notR     <= 1'b1;
      q_expect <= 1'b0;
    end else begin
      state    <= state_n;
      pcnt     <= pcnt_n;
      notS     <= nots_n;
      notR     <= notr_n;
      q_expect <= q_n;
    end
  end

  assign busy = (state != IDLE);

`ifdef KEY_SR_LATCH_CHECK_EN
  logic miss_seen;
  logic mismatch;

  assign mismatch = (state == IDLE) && (latch_q != q_expect);

  // Flag a latch that disagrees with the expected state two idle cycles running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_seen <= 1'b0;
      err       <= 1'b0;
    end else begin
      miss_seen <= mismatch;
      if (mismatch && miss_seen) begin
        err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_key_sr_driver.sv
// Self-checking bench for key_sr_driver: randomized and directed key traffic,
// a behavioural model predicting pulses, and a monitor scoreboarding them.
module tb_key_sr_driver;

  localparam int DB_LIMIT     = 8;
  localparam int PULSE_CYCLES = 4;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic key_set = 1'b0;
  logic key_clr = 1'b0;
  logic notS;
  logic notR;
  logic q_expect;
  logic busy;
`ifdef KEY_SR_LATCH_CHECK_EN
  logic latch_q = 1'b0;
  logic err;
  bit   latch_follow = 1'b1;
  bit   m_err = 1'b0;
  int   m_miss = 0;
`endif

  key_sr_driver #(
    .DB_LIMIT     (DB_LIMIT),
    .DB_W         (16),
    .PULSE_CYCLES (PULSE_CYCLES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_set  (key_set),
    .key_clr  (key_clr),
    .notS     (notS),
    .notR     (notR),
    .q_expect (q_expect),
    .busy     (busy)
`ifdef KEY_SR_LATCH_CHECK_EN
    ,
    .latch_q  (latch_q),
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_r;
    int start;
    int width;
  } pulse_t;

  pulse_t exp_q[$];
  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;

  // Behavioural model: raw key history since reset, debounced levels, and an
  // abstract mode (0 idle, 1 pulsing, 2 waiting for release).
  bit hist_s[$];
  bit hist_c[$];
  bit m_lvl_s  = 1'b0;
  bit m_lvl_c  = 1'b0;
  bit m_rise_s = 1'b0;
  bit m_rise_c = 1'b0;
  int m_mode   = 0;
  bit m_q      = 1'b0;
  bit m_ptype  = 1'b0;
  int m_pstart = 0;
  int m_pend   = 0;

  bit in_pulse = 1'b0;
  bit cur_r    = 1'b0;
  int pstart   = 0;
  int pw       = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // A level flips once the last DB_LIMIT synchronized samples all disagree with it;
  // the synchronized sample at an edge is the raw key from two edges earlier.
  function automatic bit flips(input bit h[$], input bit lvl);
    int m;
    m = h.size();
    if (m - 1 - DB_LIMIT < 0) return 1'b0;
    for (int j = m - 1 - DB_LIMIT; j <= m - 2; j++) begin
      if (h[j] == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic startPulse(input bit is_r);
    pulse_t p;
    p.is_r  = is_r;
    p.start = cyc;
    p.width = PULSE_CYCLES;
    exp_q.push_back(p);
    m_ptype  = is_r;
    m_pstart = cyc;
    m_pend   = cyc + PULSE_CYCLES;
    m_mode   = 1;
  endtask

  task automatic modelReset();
    if (m_mode == 1 && exp_q.size() > 0) begin
      exp_q[exp_q.size() - 1].width = cyc - m_pstart;
    end
    hist_s.delete();
    hist_c.delete();
    m_lvl_s  = 1'b0;
    m_lvl_c  = 1'b0;
    m_rise_s = 1'b0;
    m_rise_c = 1'b0;
    m_mode   = 0;
    m_q      = 1'b0;
`ifdef KEY_SR_LATCH_CHECK_EN
    m_err  = 1'b0;
    m_miss = 0;
`endif
  endtask

  task automatic modelStep();
    bit fs;
    bit fc;
    cyc++;
    if (!rst_n) begin
      modelReset();
      return;
    end
`ifdef KEY_SR_LATCH_CHECK_EN
    if (m_mode == 0 && latch_q != m_q) m_miss++;
    else m_miss = 0;
    if (m_miss >= 2) m_err = 1'b1;
`endif
    case (m_mode)
      0: begin
        if (m_rise_c) startPulse(1'b1);
        else if (m_rise_s) startPulse(1'b0);
      end
      1: begin
        if (cyc == m_pend) begin
          m_q    = !m_ptype;
          m_mode = 2;
        end
      end
      default: begin
        if (!m_lvl_s && !m_lvl_c) m_mode = 0;
      end
    endcase
    fs = flips(hist_s, m_lvl_s);
    fc = flips(hist_c, m_lvl_c);
    m_rise_s = fs && !m_lvl_s;
    m_rise_c = fc && !m_lvl_c;
    if (fs) m_lvl_s = !m_lvl_s;
    if (fc) m_lvl_c = !m_lvl_c;
    hist_s.push_back(key_set);
    hist_c.push_back(key_clr);
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // Monitor: per-cycle status checks and pulse capture against the scoreboard.
  initial forever begin
    pulse_t e;
    @(negedge clk);
    assert (notS || notR) else $error("[TB] notS and notR both low");
    checkOutput("never_both_low", int'(!notS && !notR), 0);
    checkOutput("busy", busy, int'(m_mode != 0));
    checkOutput("q_expect", q_expect, m_q);
`ifdef KEY_SR_LATCH_CHECK_EN
    checkOutput("err", err, m_err);
    latch_q = latch_follow ? m_q : 1'b0;
`endif
    if (!in_pulse) begin
      if (!notS || !notR) begin
        in_pulse = 1'b1;
        cur_r    = !notR;
        pstart   = cyc;
        pw       = 1;
      end
    end else if ((cur_r ? notR : notS) == 1'b0) begin
      pw++;
    end else begin
      in_pulse = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pulse: got is_r=%0d start=%0d width=%0d, expected none",
                 cur_r, pstart, pw);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pulse_type", cur_r, e.is_r);
        checkOutput("pulse_start", pstart, e.start);
        checkOutput("pulse_width", pw, e.width);
      end
    end
  end

  task automatic applyStimulus(input bit s, input bit c, input int n);
    @(negedge clk);
    key_set = s;
    key_clr = c;
    repeat (n) @(posedge clk);
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 5);

    // Held set key: one notS pulse, then wait for release.
    applyStimulus(1, 0, 20);
    applyStimulus(0, 0, 20);

    // Bouncing clear key never settles long enough to pulse.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 3);
      applyStimulus(0, 0, 2);
    end
    applyStimulus(0, 0, 15);

    // Simultaneous rise: clear wins.
    applyStimulus(1, 1, 20);
    applyStimulus(0, 0, 20);

    // Reset asserted during the second cycle of a notS pulse.
    @(negedge clk);
    key_set = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (!notS) found = 1'b1;
    end
    checkOutput("set_pulse_seen", found, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_async_notS", notS, 1);
    checkOutput("reset_async_notR", notR, 1);
    @(negedge clk);
    key_set = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 30);

    // Key already held across reset release is a fresh rise.
    @(negedge clk);
    key_set = 1'b1;
    doReset(3);
    applyStimulus(1, 0, 20);
    applyStimulus(0, 0, 20);

`ifdef KEY_SR_LATCH_CHECK_EN
    // Latch stuck low after a set pulse raises the sticky error.
    applyStimulus(1, 0, 20);
    latch_follow = 1'b0;
    applyStimulus(0, 0, 25);
    checkOutput("err_sticky", err, 1);
    doReset(2);
    latch_follow = 1'b1;
    #1;
    checkOutput("err_cleared", err, 0);
    applyStimulus(0, 0, 5);
`endif

    // Randomized key traffic.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 14));
    end
    applyStimulus(0, 0, 40);

    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("no_open_pulse", in_pulse, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound the whole run in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/key_sr_driver.md
KEY_SR_DRIVER -- requirements
Module: key_sr_driver

Interface
REQ-001 SHALL have parameter DB_LIMIT, default 50000, meaning the number of stable cycles required to accept a key level.
REQ-002 SHALL have parameter DB_W, default 16, meaning the debounce counter width; DB_LIMIT < 2**DB_W.
REQ-003 SHALL have parameter PULSE_CYCLES, default 4, meaning the active-low pulse width on notS/notR in clock cycles; the legal range is 1..15.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk input 1 system clock, rising edge; rst_n input 1 asynchronous active-low reset.
REQ-005 key_set input 1: raw, asynchronous set button, active-high.
REQ-006 key_clr input 1: raw, asynchronous clear button, active-high.
REQ-007 notS output 1: active-low set request to the downstream NAND SR latch.
REQ-008 notR output 1: active-low reset request to the downstream NAND SR latch.
REQ-009 q_expect output 1: latch state implied by the last completed pulse.
REQ-010 busy output 1: high while a pulse is being issued or a key release is awaited.

Function
REQ-011 SHALL pass each key through a 2-flop synchronizer, then a debouncer; a debounced level changes only after DB_LIMIT consecutive cycles of the opposite synchronized level.
REQ-012 SHALL implement the FSM states IDLE, PULSE_S, PULSE_R and WAIT_REL.
REQ-013 IDLE: a debounced set rise moves to PULSE_S and a debounced clr rise moves to PULSE_R; if both rise in the same cycle, clr wins.
REQ-014 PULSE_S and PULSE_R SHALL drive notS=0 or notR=0 respectively for exactly PULSE_CYCLES cycles, then go to WAIT_REL.
REQ-015 On leaving PULSE_S, q_expect SHALL become 1; on leaving PULSE_R, q_expect SHALL become 0.
REQ-016 WAIT_REL SHALL return to IDLE only when both debounced keys are low; new key edges are ignored until then.
REQ-017 notS and notR SHALL never both be 0 in any cycle, including the reset and reset-release cycles.
REQ-018 notS and notR SHALL be registered outputs, glitch-free and driven directly from flops.
REQ-019 Latency: notS or notR goes low 1 cycle after the debounced edge is detected in IDLE.
REQ-020 busy SHALL be 1 in PULSE_S, PULSE_R and WAIT_REL, and 0 in IDLE.
REQ-021 A key that is held continuously SHALL produce exactly one pulse.

Reset
REQ-022 While rst_n=0, the block SHALL hold: notS=1, notR=1, q_expect=0, busy=0, FSM=IDLE, debounce counters=0, debounced levels=0, synchronizers=0.
REQ-023 Reset asserted mid-pulse SHALL immediately release notS/notR to 1 (asynchronously) with no partial pulse afterwards.
REQ-024 After reset release, a key already held SHALL be treated as a new rise once debounced.

Configuration
REQ-025 Macro KEY_SR_LATCH_CHECK_EN, when defined, SHALL add input latch_q (1 bit) and output err (1 bit, sticky, reset 0).
REQ-026 With KEY_SR_LATCH_CHECK_EN, err SHALL set when latch_q != q_expect in IDLE for 2 consecutive cycles; only rst_n clears err.
REQ-027 Without KEY_SR_LATCH_CHECK_EN, the ports latch_q and err SHALL not exist and no check logic SHALL be synthesized.

Structure
REQ-028 Package key_sr_pkg SHALL hold the FSM state enum (IDLE, PULSE_S, PULSE_R, WAIT_REL) and the pulse-width counter width constant (4).
REQ-029 Sub-module key_debounce (synchronizer plus counter, one instance per key) SHALL be parameterized by DB_LIMIT and DB_W.
REQ-030 The remainder of the block (FSM, pulse counter, check logic) SHALL live in key_sr_driver.

Verification (DB_LIMIT=8 and PULSE_CYCLES=4 for simulation)
REQ-031 Hold key_set high for 20 cycles -> notS low for exactly 4 cycles starting 2+8+1 cycles after the rise; then q_expect=1, busy high until release+debounce.
REQ-032 Bounce key_clr (3 cycles high, 2 low, repeated) for 30 cycles -> notR stays 1 throughout; q_expect unchanged.
REQ-033 Raise key_set and key_clr in the same cycle -> only notR pulses (4 cycles); notS stays 1; q_expect=0.
REQ-034 Assert rst_n=0 in the 2nd cycle of a notS pulse -> notS=1 in the same cycle; after release with keys low, no pulse and q_expect=0.
REQ-035 With KEY_SR_LATCH_CHECK_EN defined, after a set pulse hold latch_q=0 -> err=1 on the 2nd IDLE cycle and remains 1 until rst_n=0.
REQ-036 Every scenario SHALL also check, every cycle, the assertion that notS and notR are never both 0.
